example_mul_rr_arb: RTL and testbench
=====================================

EXAMPLE_MUL_RR_ARB -- requirements
Module: example_mul_rr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requester ports (2..8).
REQ-002 Parameter ID_W, default 2, SHALL set the requester-index width, with ID_W = clog2(NUM_REQ).
REQ-003 ap_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 ap_rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 req_valid  in  NUM_REQ  SHALL carry the per-requester operand-valid flags.
REQ-006 req_ready  out  NUM_REQ  SHALL carry the per-requester accept strobes.
REQ-007 req_a  in  NUM_REQ*6  SHALL carry the packed signed 6-bit multiplicands; requester i occupies bits [6i+5:6i].
REQ-008 req_b  in  NUM_REQ*14  SHALL carry the packed signed 14-bit multipliers; requester i occupies bits [14i+13:14i].
REQ-009 res_valid  out  1  SHALL flag that a product is available.
REQ-010 res_ready  in  1  SHALL be the downstream accept for the product.
REQ-011 res_p  out  20  SHALL carry the signed product.
REQ-012 res_id  out  ID_W  SHALL carry the index of the requester that owns res_p.
REQ-013 busy  out  1  SHALL be high while either pipeline stage holds valid data.
REQ-014 op_count  out  16  SHALL count completed result handshakes.

Function
REQ-015 One shared signed 6x14 multiplier SHALL be time-multiplexed among all requesters.
REQ-016 Arbitration SHALL be round-robin: search starts at pointer rr_ptr and takes the first i with req_valid[i]=1, in order rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
REQ-017 Advance enable SHALL be en = !res_valid || res_ready.
REQ-018 req_ready[i] SHALL be high only when en=1 and i is the current grant.
  - At most one req_ready bit high per cycle.
  - Combinational dependence on res_ready is permitted.
REQ-019 On an accept at requester g, rr_ptr SHALL become (g+1) mod NUM_REQ at the next edge; otherwise rr_ptr SHALL hold.
REQ-020 Pipeline SHALL have two register stages:
  - S1 holds a, b and id.
  - S2 holds p = a*b and id, and drives res_p, res_id and res_valid.
REQ-021 Latency SHALL be 2 cycles: an accept in cycle c yields res_valid=1 in cycle c+2, provided no stall occurs.
REQ-022 Throughput SHALL be one accept per cycle while res_ready=1.
REQ-023 Stall (res_valid=1, res_ready=0) behaviour SHALL be:
  - S1, S2 and rr_ptr hold.
  - All req_ready bits are 0.
  - res_p and res_id are stable.
REQ-024 A bubble in S1 SHALL propagate as res_valid=0; S2 SHALL load even when S1 is empty, so a drained S2 clears.
REQ-025 Multiplication SHALL be full-precision two's-complement, sign-extended to 20 bits with no truncation; the extreme case (-32)*(-8192) = +262144 is in range.
REQ-026 op_count SHALL increment on each res_valid and res_ready cycle and saturate at 0xFFFF.
REQ-027 A requester SHALL hold its operands stable while req_valid=1 and it is not accepted; the block SHALL NOT register operands it has not accepted.
REQ-028 With no req_valid asserted, the block SHALL accept nothing and rr_ptr SHALL hold.

Reset
REQ-029 While ap_rst=1, at each edge:
  - S1 and S2 valid flags clear.
  - rr_ptr = 0 and op_count = 0.
  - res_p = 0 and res_id = 0.
REQ-030 During and after reset, until the first accept: req_ready = 0 during reset, res_valid = 0 and busy = 0.
REQ-031 Reset mid-operation SHALL discard in-flight products with no res_valid pulse for them.

Structure
REQ-032 Constants SHALL live in a shared package example_mul_pkg:
  - A_W = 6, B_W = 14, P_W = 20.
  - OPCNT_W = 16.
REQ-033 The multiplier SHALL be a single combinational sub-module, example_mul_dsp_core (signed A_W x B_W -> P_W), instantiated once between S1 and S2.
REQ-034 The arbiter, pointer, pipeline registers and counter SHALL be in example_mul_rr_arb.

Verification
REQ-035 Single request: req_valid=0001, a=3, b=-5, res_ready=1 -> req_ready[0]=1 in cycle 0; res_valid=1, res_p=-15, res_id=0 in cycle 2.
REQ-036 All four requests held continuously, res_ready=1 -> grants in order 0,1,2,3,0,...; one result per cycle; each res_p matches its requester's a*b.
REQ-037 Extremes: a=-32, b=-8192 -> res_p=262144; a=31, b=-8192 -> res_p=-253952.
REQ-038 Backpressure: res_ready=0 for 5 cycles with S1 and S2 full -> all req_ready=0, res_p/res_id stable, no result lost or duplicated after release, op_count increments exactly once per result.
REQ-039 Reset asserted one cycle after an accept -> no res_valid for that request, rr_ptr=0, op_count=0, busy=0 the cycle after reset deasserts.
REQ-040 Saturation: force 65537 result handshakes -> op_count=0xFFFF and holds.

Source files
------------

// File: rtl/example_mul_pkg.sv
// Shared widths and payload types for the arbitrated shared-multiplier block.
package example_mul_pkg;

    localparam int unsigned A_W     = 6;
    localparam int unsigned B_W     = 14;
    localparam int unsigned P_W     = 20;
    localparam int unsigned OPCNT_W = 16;

    typedef struct packed {
        logic signed [A_W-1:0] a;
        logic signed [B_W-1:0] b;
    } operand_t;

endpackage

// File: rtl/example_mul_dsp_core.sv
// Combinational signed A_W x B_W multiplier producing a full-precision P_W result.
module example_mul_dsp_core
    import example_mul_pkg::*;
(
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    output logic signed [P_W-1:0] p
);

    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] b_ext;

    // P_W covers A_W+B_W, so the low P_W bits of the extended product are exact.
    assign a_ext = {{(P_W-A_W){a[A_W-1]}}, a};
    assign b_ext = {{(P_W-B_W){b[B_W-1]}}, b};
    assign p     = a_ext * b_ext;

endmodule

// File: rtl/example_mul_rr_arb.sv
// Round-robin arbiter sharing one signed multiplier across NUM_REQ requesters, 2-stage pipeline.
module example_mul_rr_arb
    import example_mul_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*A_W-1:0]   req_a,
    input  logic [NUM_REQ*B_W-1:0]   req_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [P_W-1:0]           res_p,
    output logic [ID_W-1:0]          res_id,
    output logic                     busy,
    output logic [OPCNT_W-1:0]       op_count
);

    logic              en;
    logic              any_valid;
    logic              accept;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   ptr_next;
    operand_t          sel_op;

    logic              s1_valid;
    operand_t          s1_op;
    logic [ID_W-1:0]   s1_id;
    logic              s2_valid;
    logic signed [P_W-1:0] prod;

    // Scan from the highest offset down so the requester nearest rr_ptr wins.
    always_comb begin
        int unsigned idx;
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid[ID_W'(idx)]) begin
                grant     = ID_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

    assign en       = !s2_valid || res_ready;
    assign accept   = en && any_valid && !ap_rst;
    assign ptr_next = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        sel_op.a = req_a[int'(grant)*A_W +: A_W];
        sel_op.b = req_b[int'(grant)*B_W +: B_W];
    end

    example_mul_dsp_core u_core (
        .a (s1_op.a),
        .b (s1_op.b),
        .p (prod)
    );

    // Pipeline, pointer and handshake counter; everything but op_count freezes on stall.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            res_p    <= '0;
            res_id   <= '0;
            rr_ptr   <= '0;
            op_count <= '0;
        end else begin
            if (en) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_op <= sel_op;
                    s1_id <= grant;
                end
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    res_p  <= prod;
                    res_id <= s1_id;
                end
            end
            if (accept) begin
                rr_ptr <= ptr_next;
            end
            if (s2_valid && res_ready && (op_count != '1)) begin
                op_count <= op_count + OPCNT_W'(1);
            end
        end
    end

    assign res_valid = s2_valid;
    assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_example_mul_rr_arb.sv
// Scoreboard bench for example_mul_rr_arb: round-robin reference model plus result monitor.
module tb_example_mul_rr_arb;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic             ap_clk = 1'b0;
    logic             ap_rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*6-1:0]   req_a;
    logic [N*14-1:0]  req_b;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [19:0]      res_p;
    logic [IDW-1:0]   res_id;
    logic             busy;
    logic [15:0]      op_count;

    example_mul_rr_arb #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_p     (res_p),
        .res_id    (res_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 ap_clk = ~ap_clk;

    int op_a [N];
    int op_b [N];
    int total = 0;
    int bad   = 0;

    typedef struct {
        int id;
        int p;
    } exp_t;
    exp_t exp_q[$];

    int           model_ptr = 0;
    int           model_cnt = 0;
    logic [N-1:0] last_acc  = '0;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*6 +: 6]   = 6'(op_a[i]);
            req_b[i*14 +: 14] = 14'(op_b[i]);
        end
    end

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference arbiter: predicts the grant and queues the expected product.
    always @(negedge ap_clk) begin : arb_model
        int           g;
        logic [N-1:0] exp_rdy;
        if (ap_rst) begin
            model_ptr = 0;
            exp_q.delete();
            last_acc = '0;
            check("ready_in_reset", req_ready, 0);
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(model_ptr + k) % N]) g = (model_ptr + k) % N;
            end
            exp_rdy = '0;
            if ((!res_valid || res_ready) && g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", req_ready, exp_rdy);
            last_acc = exp_rdy;
            if (g >= 0 && exp_rdy != '0) begin
                exp_q.push_back('{g, op_a[g] * op_b[g]});
                model_ptr = (g + 1) % N;
            end
        end
    end

    // Monitor: pops the scoreboard on every result handshake and tracks op_count.
    always @(negedge ap_clk) begin : monitor
        exp_t e;
        if (ap_rst) begin
            model_cnt = 0;
        end else begin
            check("op_count", op_count, model_cnt);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_id", res_id, e.id);
                    check("res_p", $signed(res_p), e.p);
                end
                if (model_cnt < 65535) model_cnt++;
            end
        end
    end

    task automatic rand_step(input int dens, input int rdy_pct);
        @(posedge ap_clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (!(req_valid[i] && !last_acc[i])) begin
                req_valid[i] = ($urandom_range(99) < dens);
                op_a[i] = int'($urandom_range(63)) - 32;
                op_b[i] = int'($urandom_range(16383)) - 8192;
            end
        end
        res_ready = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic drive(input logic [N-1:0] v, input logic r);
        @(posedge ap_clk);
        #1;
        req_valid = v;
        res_ready = r;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        req_valid = '0;
        res_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && guard < 30) begin
            @(posedge ap_clk);
            guard++;
        end
        @(negedge ap_clk);
        check("drain_empty", exp_q.size(), 0);
    endtask

    logic [19:0]    hold_p;
    logic [IDW-1:0] hold_id;

    initial begin
        for (int i = 0; i < N; i++) begin
            op_a[i] = 0;
            op_b[i] = 0;
        end
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_op_count", op_count, 0);
        check("rst_res_p", res_p, 0);
        check("rst_res_id", res_id, 0);
        @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        @(negedge ap_clk);
        check("post_rst_busy", busy, 0);

        // Single request latency
        op_a[0] = 3;
        op_b[0] = -5;
        drive(4'b0001, 1'b1);
        @(negedge ap_clk);
        check("single_ready", req_ready, 1);
        drive(4'b0000, 1'b1);
        @(negedge ap_clk);
        check("single_c1_valid", res_valid, 0);
        check("single_c1_busy", busy, 1);
        @(negedge ap_clk);
        check("single_c2_valid", res_valid, 1);
        check("single_c2_p", $signed(res_p), -15);
        check("single_c2_id", res_id, 0);
        repeat (2) @(posedge ap_clk);

        // All requesters held, with extreme operands on 0 and 1
        op_a[0] = -32; op_b[0] = -8192;
        op_a[1] = 31;  op_b[1] = -8192;
        op_a[2] = -7;  op_b[2] = 1234;
        op_a[3] = 17;  op_b[3] = 8191;
        for (int k = 0; k < 10; k++) begin
            drive(4'b1111, 1'b1);
            @(negedge ap_clk);
            check("rr_order", req_ready, 1 << ((1 + k) % N));
            if (k >= 2) check("rr_throughput", res_valid, 1);
            if (res_valid && res_id == 0) check("extreme_pos", $signed(res_p), 262144);
            if (res_valid && res_id == 1) check("extreme_neg", $signed(res_p), -253952);
        end

        // Backpressure with both stages full
        drive(4'b1111, 1'b0);
        @(negedge ap_clk);
        hold_p  = res_p;
        hold_id = res_id;
        check("stall_busy", busy, 1);
        for (int k = 0; k < 4; k++) begin
            drive(4'b1111, 1'b0);
            @(negedge ap_clk);
            check("stall_ready", req_ready, 0);
            check("stall_p", res_p, hold_p);
            check("stall_id", res_id, hold_id);
            check("stall_valid", res_valid, 1);
        end
        repeat (4) drive(4'b1111, 1'b1);
        drain();

        // Reset one cycle after an accept
        op_a[2] = 5;
        op_b[2] = 9;
        drive(4'b0100, 1'b1);
        @(negedge ap_clk);
        check("pre_rst_ready", req_ready, 4'b0100);
        @(posedge ap_clk);
        #1;
        req_valid = '0;
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        @(negedge ap_clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_op_count", op_count, 0);
        check("mid_rst_valid", res_valid, 0);
        repeat (3) begin
            @(negedge ap_clk);
            check("mid_rst_no_result", res_valid, 0);
        end
        drive(4'b1111, 1'b1);
        @(negedge ap_clk);
        check("mid_rst_ptr0", req_ready, 4'b0001);
        drain();

        // Randomized traffic with random backpressure
        for (int c = 0; c < 2000; c++) rand_step(55, 70);
        drain();

        // Counter saturation
        for (int c = 0; c < 65545; c++) drive(4'b1111, 1'b1);
        @(negedge ap_clk);
        check("sat_value", op_count, 16'hFFFF);
        repeat (3) drive(4'b1111, 1'b1);
        @(negedge ap_clk);
        check("sat_hold", op_count, 16'hFFFF);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
